// File: rtl/gate_sweep_checker.sv
// Exhaustive 2-input gate checker: drives 00,01,10,11, samples after settle, compares to a truth table.
// Sweep takes 4*(SETTLE_CYCLES+2) cycles from start to done; start is ignored unless idle.
module gate_sweep_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       truth_table,
   input  logic             dut_y,
   output logic             dut_a,
   output logic             dut_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   state_t           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [3:0]       tt_q, tt_d;
   logic             a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [3:0]       fail_q, fail_d;
   logic             pass_q, pass_d;
   logic             mismatch;
   logic [1:0]       vec_nxt;
   logic [3:0]       fail_nxt;

   assign mismatch = (dut_y != tt_q[vec_q]);
   assign vec_nxt  = vec_q + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_DRIVE;
         S_DRIVE:  state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
         S_SETTLE: if (cnt_q <= SW'(1)) state_d = S_SAMPLE;
         S_SAMPLE: state_d = (vec_q == 2'd3) ? S_DONE : S_DRIVE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      done = (state_q == S_DONE);
   end

   // Datapath: vector inputs are loaded on the edge that enters DRIVE and held until the next one.
   always_comb begin
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      tt_d     = tt_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      fail_nxt = fail_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               tt_d   = truth_table;
               err_d  = '0;
               fail_d = 4'b0000;
               pass_d = 1'b0;
               vec_d  = 2'd0;
               a_d    = 1'b0;
               b_d    = 1'b0;
            end
         end
         S_DRIVE: begin
            cnt_d = SW'(SETTLE_CYCLES);
         end
         S_SETTLE: begin
            cnt_d = cnt_q - SW'(1);
         end
         S_SAMPLE: begin
            if (mismatch) begin
               fail_nxt[vec_q] = 1'b1;
               if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
            end
            fail_d = fail_nxt;
            if (vec_q == 2'd3) begin
               a_d    = 1'b0;
               b_d    = 1'b0;
               pass_d = (fail_nxt == 4'b0000);
            end else begin
               vec_d = vec_nxt;
               a_d   = vec_nxt[1];
               b_d   = vec_nxt[0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q  <= 2'd0;
         cnt_q  <= '0;
         tt_q   <= 4'b0000;
         a_q    <= 1'b0;
         b_q    <= 1'b0;
         err_q  <= '0;
         fail_q <= 4'b0000;
         pass_q <= 1'b0;
      end else begin
         vec_q  <= vec_d;
         cnt_q  <= cnt_d;
         tt_q   <= tt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         err_q  <= err_d;
         fail_q <= fail_d;
         pass_q <= pass_d;
      end
   end

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (default, CNT_W=1, SETTLE_CYCLES=0) with behavioural gates.
module tb_gate_sweep_checker;

   typedef struct {
      int         idx;
      logic [1:0] mode;     // 0: xnor, 1: tied 0, 2: xor (inverted xnor)
      logic [3:0] tt;
      int         glitch;   // edge at which a stray start is pulsed, -1 for none
      logic [3:0] exp_fv;
      int         exp_err;
      logic       exp_pass;
      int         exp_lat;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [2:0] start_r;
   logic [1:0] mode_r [3];
   logic [3:0] tt_r   [3];
   logic [2:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
   logic [3:0] fv_w   [3];
   logic [3:0] err_w  [3];
   logic [3:0] err0, err2;
   logic [0:0] err1;

   int   n_checks;
   int   n_fail;
   vec_t exp_q[$];
   vec_t tbl[10];

   function automatic logic gate_f(input logic [1:0] m, input logic a, input logic b);
      case (m)
         2'd0:    return ~(a ^ b);
         2'd1:    return 1'b0;
         default: return a ^ b;
      endcase
   endfunction

   assign y_w[0]  = gate_f(mode_r[0], a_w[0], b_w[0]);
   assign y_w[1]  = gate_f(mode_r[1], a_w[1], b_w[1]);
   assign y_w[2]  = gate_f(mode_r[2], a_w[2], b_w[2]);
   assign err_w[0] = err0;
   assign err_w[1] = {3'b000, err1};
   assign err_w[2] = err2;

   gate_sweep_checker u_dut0 (
      .clk(clk), .rst(rst), .start(start_r[0]), .truth_table(tt_r[0]), .dut_y(y_w[0]),
      .dut_a(a_w[0]), .dut_b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err0), .fail_vec(fv_w[0])
   );

   gate_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_r[1]), .truth_table(tt_r[1]), .dut_y(y_w[1]),
      .dut_a(a_w[1]), .dut_b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err1), .fail_vec(fv_w[1])
   );

   gate_sweep_checker #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_r[2]), .truth_table(tt_r[2]), .dut_y(y_w[2]),
      .dut_a(a_w[2]), .dut_b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .err_count(err2), .fail_vec(fv_w[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int outs_word(input int i);
      return {a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], fv_w[i], err_w[i]};
   endfunction

   task automatic run_sweep(input vec_t v);
      int   e;
      int   hold;
      logic seq_ok;
      logic got_done;
      logic stray;
      vec_t ex;
      hold = v.exp_lat / 4;
      @(negedge clk);
      mode_r[v.idx]  = v.mode;
      tt_r[v.idx]    = v.tt;
      start_r[v.idx] = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      start_r[v.idx] = 1'b0;
      tt_r[v.idx]    = ~v.tt;   // post-capture changes must not matter
      e        = 0;
      seq_ok   = 1'b1;
      got_done = 1'b0;
      while (!got_done && e < 200) begin
         if (done_w[v.idx]) begin
            got_done = 1'b1;
         end else begin
            if ({a_w[v.idx], b_w[v.idx]} != 2'(e / hold)) seq_ok = 1'b0;
            if (busy_w[v.idx] !== 1'b1) seq_ok = 1'b0;
            start_r[v.idx] = (v.glitch >= 0 && e == v.glitch - 1);
            @(negedge clk);
            e++;
         end
      end
      start_r[v.idx] = 1'b0;
      ex = exp_q.pop_front();
      check("done_seen", got_done, 1);
      check("done_latency", e, ex.exp_lat);
      check("drive_seq", seq_ok, 1);
      check("fail_vec", fv_w[ex.idx], ex.exp_fv);
      check("err_count", err_w[ex.idx], ex.exp_err);
      check("pass", pass_w[ex.idx], ex.exp_pass);
      check("ab_at_done", {a_w[ex.idx], b_w[ex.idx], busy_w[ex.idx]}, 0);
      @(negedge clk);
      check("done_one_cycle", done_w[ex.idx], 0);
      check("pass_held", pass_w[ex.idx], ex.exp_pass);
      if (v.glitch >= 0) begin
         stray = 1'b0;
         repeat (12) begin
            @(negedge clk);
            if (busy_w[v.idx] || done_w[v.idx]) stray = 1'b1;
         end
         check("no_restart", stray, 0);
      end
   endtask

   initial begin
      logic saw_done;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start_r  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         mode_r[i] = 2'd0;
         tt_r[i]   = 4'b0000;
      end

      //          idx mode   tt       glitch fv       err pass lat
      tbl[0] = '{0, 2'd0, 4'b1001, -1, 4'b0000, 0, 1'b1, 16};
      tbl[1] = '{0, 2'd1, 4'b1001, -1, 4'b1001, 2, 1'b0, 16};
      tbl[2] = '{1, 2'd2, 4'b1001, -1, 4'b1111, 1, 1'b0, 16};
      tbl[3] = '{1, 2'd0, 4'b1001, -1, 4'b0000, 0, 1'b1, 16};
      tbl[4] = '{2, 2'd0, 4'b1001,  3, 4'b0000, 0, 1'b1, 8};
      tbl[5] = '{0, 2'd0, 4'b0110, -1, 4'b1111, 4, 1'b0, 16};
      tbl[6] = '{2, 2'd1, 4'b0000, -1, 4'b0000, 0, 1'b1, 8};
      tbl[7] = '{2, 2'd2, 4'b0110, -1, 4'b0000, 0, 1'b1, 8};
      tbl[8] = '{0, 2'd2, 4'b1000, -1, 4'b1110, 3, 1'b0, 16};
      tbl[9] = '{0, 2'd0, 4'b1001, -1, 4'b0000, 0, 1'b1, 16};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) check("reset_outs", outs_word(i), 0);
      repeat (3) @(negedge clk);
      check("idle_no_drive", {a_w, b_w, busy_w, done_w}, 0);

      for (int t = 0; t < 9; t++) run_sweep(tbl[t]);

      // Abort a sweep with reset right after edge 9.
      @(negedge clk);
      mode_r[0]  = 2'd0;
      tt_r[0]    = 4'b1001;
      start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_sweep_busy", busy_w[0], 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("abort_outs", outs_word(0), 0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done_w[0] || busy_w[0]) saw_done = 1'b1;
      end
      check("abort_no_resume", saw_done, 0);

      run_sweep(tbl[9]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
